// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for a 5-stage RV32I pipeline: load-use bubbles, memory freezes,
// redirect squashing (including a late wrong-path fetch) and saturating perf counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_num,
  input  logic [4:0]       id_rs2_num,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd_num,
  input  logic             ex_is_load,
  input  logic             ex_redirect,
  input  logic             imem_read,
  input  logic             imem_resp,
  input  logic             dmem_read,
  input  logic             dmem_write,
  input  logic             dmem_resp,
  input  logic             perf_clr,
  output logic             pc_load,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_mem_stall,
  output logic             mem_wb_stall,
  output logic             if_id_clear,
  output logic             id_ex_clear,
  output logic             ex_mem_clear,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] bubble_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t state, state_next;
  logic   dmem_busy, imem_busy, lu;
  logic   freeze, redirect, flushing, bubble;
  logic   pc_load_c, if_id_stall_c, id_ex_stall_c, ex_mem_stall_c, mem_wb_stall_c;
  logic   if_id_clear_c, id_ex_clear_c, ex_mem_clear_c;

  assign dmem_busy = (dmem_read | dmem_write) & ~dmem_resp;
  assign imem_busy = imem_read & ~imem_resp;
  assign lu = ex_is_load & (ex_rd_num != 5'd0) &
              ((id_uses_rs1 & (id_rs1_num == ex_rd_num)) |
               (id_uses_rs2 & (id_rs2_num == ex_rd_num)));

  // A redirect beats the fetch wait: the outstanding fetch is wrong-path, and FLUSH absorbs it.
  assign freeze   = dmem_busy | ((state == RUN) & imem_busy & ~ex_redirect);
  assign redirect = (state == RUN) & ex_redirect & ~freeze;
  assign flushing = (state == FLUSH) & ~freeze;
  assign bubble   = (state == RUN) & lu & ~freeze & ~redirect;

  always_comb begin
    // NOTE: every signal gets a default here so no path leaves one unassigned (no latches).
    pc_load_c      = 1'b1;
    if_id_stall_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    mem_wb_stall_c = 1'b0;
    if_id_clear_c  = 1'b0;
    id_ex_clear_c  = 1'b0;
    ex_mem_clear_c = 1'b0;
    state_next     = state;

    if (freeze) begin
      pc_load_c      = 1'b0;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_stall_c = 1'b1;
      mem_wb_stall_c = 1'b1;
      if ((state == FLUSH) && imem_resp) state_next = RUN;
    end else if (flushing) begin
      pc_load_c     = 1'b0;
      if_id_clear_c = 1'b1;
      if (imem_resp) state_next = RUN;
    end else if (redirect) begin
      if_id_clear_c = 1'b1;
      id_ex_clear_c = 1'b1;
      state_next    = imem_busy ? FLUSH : RUN;
    end else if (bubble) begin
      pc_load_c     = 1'b0;
      if_id_stall_c = 1'b1;
      id_ex_clear_c = 1'b1;
    end
  end

  // A stalled stage is never cleared; reset forces every buffer to a bubble.
  assign pc_load      = ~rst & pc_load_c;
  assign if_id_stall  = ~rst & if_id_stall_c;
  assign id_ex_stall  = ~rst & id_ex_stall_c;
  assign ex_mem_stall = ~rst & ex_mem_stall_c;
  assign mem_wb_stall = ~rst & mem_wb_stall_c;
  assign if_id_clear  = rst | (if_id_clear_c & ~if_id_stall_c);
  assign id_ex_clear  = rst | (id_ex_clear_c & ~id_ex_stall_c);
  assign ex_mem_clear = rst | (ex_mem_clear_c & ~ex_mem_stall_c);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      stall_cycles <= '0;
      bubble_count <= '0;
      flush_count  <= '0;
    end else begin
      state <= state_next;
      if (perf_clr) begin
        stall_cycles <= '0;
        bubble_count <= '0;
        flush_count  <= '0;
      end else begin
        if (freeze)   stall_cycles <= sat_inc(stall_cycles);
        if (bubble)   bubble_count <= sat_inc(bubble_count);
        if (redirect) flush_count  <= sat_inc(flush_count);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench: driver pushes model expectations, a monitor on the falling edge pops and
// compares outputs and counters. Narrow counters make saturation reachable.
module tb_pipeline_hazard_ctrl;

  localparam int W   = 5;
  localparam int MAX = (1 << W) - 1;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       ld;
    logic       redir;
    logic       ir;
    logic       iresp;
    logic       dr;
    logic       dw;
    logic       dresp;
    logic       pclr;
  } stim_t;

  typedef struct packed {
    logic [7:0]   outs;  // {pc_load, stalls if/id..mem/wb, clears if/id..ex/mem}
    logic [W-1:0] sc;
    logic [W-1:0] bc;
    logic [W-1:0] fc;
  } exp_t;

  logic         clk, rst;
  logic [4:0]   id_rs1_num, id_rs2_num, ex_rd_num;
  logic         id_uses_rs1, id_uses_rs2, ex_is_load, ex_redirect;
  logic         imem_read, imem_resp, dmem_read, dmem_write, dmem_resp, perf_clr;
  logic         pc_load, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall;
  logic         if_id_clear, id_ex_clear, ex_mem_clear;
  logic [W-1:0] stall_cycles, bubble_count, flush_count;

  pipeline_hazard_ctrl #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_num(id_rs1_num), .id_rs2_num(id_rs2_num),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_num(ex_rd_num), .ex_is_load(ex_is_load), .ex_redirect(ex_redirect),
    .imem_read(imem_read), .imem_resp(imem_resp),
    .dmem_read(dmem_read), .dmem_write(dmem_write), .dmem_resp(dmem_resp),
    .perf_clr(perf_clr), .pc_load(pc_load),
    .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
    .if_id_clear(if_id_clear), .id_ex_clear(id_ex_clear), .ex_mem_clear(ex_mem_clear),
    .stall_cycles(stall_cycles), .bubble_count(bubble_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: pipeline mode plus three plain integer counters.
  bit m_flush;
  int m_sc, m_bc, m_fc;

  function automatic int sat(input int v);
    return (v >= MAX) ? MAX : v + 1;
  endfunction

  task automatic model(input stim_t s, output exp_t e);
    bit         dbusy, ibusy, lu, pc;
    logic [3:0] st;
    logic [2:0] cl;
    if (s.rst) begin
      m_flush = 0; m_sc = 0; m_bc = 0; m_fc = 0;
      e = '{outs: 8'b0_0000_111, sc: '0, bc: '0, fc: '0};
      return;
    end
    dbusy = (s.dr || s.dw) && !s.dresp;
    ibusy = s.ir && !s.iresp;
    lu    = s.ld && (s.rd != 0) &&
            ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
    e.sc = W'(m_sc); e.bc = W'(m_bc); e.fc = W'(m_fc);
    pc = 1; st = 4'b0000; cl = 3'b000;
    if (dbusy || (!m_flush && ibusy && !s.redir)) begin
      pc = 0; st = 4'b1111; m_sc = sat(m_sc);
      if (m_flush && s.iresp) m_flush = 0;
    end else if (m_flush) begin
      pc = 0; cl = 3'b100;
      if (s.iresp) m_flush = 0;
    end else if (s.redir) begin
      cl = 3'b110; m_fc = sat(m_fc); m_flush = ibusy;
    end else if (lu) begin
      pc = 0; st = 4'b1000; cl = 3'b010; m_bc = sat(m_bc);
    end
    if (s.pclr) begin m_sc = 0; m_bc = 0; m_fc = 0; end
    e.outs = {pc, st, cl};
  endtask

  task automatic apply(input stim_t s);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst; id_rs1_num = s.rs1; id_rs2_num = s.rs2;
    id_uses_rs1 = s.u1; id_uses_rs2 = s.u2; ex_rd_num = s.rd; ex_is_load = s.ld;
    ex_redirect = s.redir; imem_read = s.ir; imem_resp = s.iresp;
    dmem_read = s.dr; dmem_write = s.dw; dmem_resp = s.dresp; perf_clr = s.pclr;
    model(s, e);
    q.push_back(e);
  endtask

  function automatic stim_t lu_pat(input logic [4:0] rd);
    stim_t s = '0;
    s.ld = 1; s.rd = rd; s.rs2 = 5'd5; s.u2 = 1;
    return s;
  endfunction

  exp_t mon_e;
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      check("outs", 32'({pc_load, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_stall,
                         if_id_clear, id_ex_clear, ex_mem_clear}), 32'(mon_e.outs));
      check("stall_cycles", 32'(stall_cycles), 32'(mon_e.sc));
      check("bubble_count", 32'(bubble_count), 32'(mon_e.bc));
      check("flush_count", 32'(flush_count), 32'(mon_e.fc));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    rst = 1; id_rs1_num = 0; id_rs2_num = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
    ex_rd_num = 0; ex_is_load = 0; ex_redirect = 0; imem_read = 0; imem_resp = 0;
    dmem_read = 0; dmem_write = 0; dmem_resp = 0; perf_clr = 0;

    s = '0; s.rst = 1; apply(s); apply(s);
    s = '0; apply(s);

    // Load-use hazard, then the same pattern against x0.
    apply(lu_pat(5'd5)); s = '0; apply(s);
    apply(lu_pat(5'd0)); s = '0; apply(s);

    // Data-memory wait of three cycles.
    s = '0; s.dr = 1; repeat (3) apply(s);
    s.dresp = 1; apply(s);
    s = '0; apply(s);

    // Redirect with idle instruction memory.
    s = '0; s.redir = 1; apply(s);
    s = '0; apply(s);

    // Redirect with a fetch in flight; response two cycles later.
    s = '0; s.redir = 1; s.ir = 1; apply(s);
    s = '0; s.ir = 1; repeat (2) apply(s);
    s.iresp = 1; apply(s);
    s = '0; apply(s);

    // Freeze dominates a simultaneous redirect and load-use.
    s = lu_pat(5'd5); s.redir = 1; s.dr = 1; repeat (2) apply(s);
    s.dresp = 1; apply(s);
    s = '0; apply(s);

    // Reset asserted mid-FLUSH.
    s = '0; s.redir = 1; s.ir = 1; apply(s);
    s = '0; s.ir = 1; apply(s);
    s.rst = 1; apply(s);
    s = '0; apply(s); apply(s);

    // Saturate bubble_count, keep hammering, then clear.
    repeat (MAX + 3) apply(lu_pat(5'd5));
    s = '0; s.pclr = 1; apply(s);
    s = '0; apply(s);

    // Randomized traffic with small register indices to provoke hazards.
    for (int i = 0; i < 2000; i++) begin
      s.rst   = ($urandom_range(0, 199) == 0);
      s.rs1   = 5'($urandom_range(0, 3));
      s.rs2   = 5'($urandom_range(0, 3));
      s.rd    = 5'($urandom_range(0, 3));
      s.u1    = 1'($urandom_range(0, 1));
      s.u2    = 1'($urandom_range(0, 1));
      s.ld    = ($urandom_range(0, 9) < 4);
      s.redir = ($urandom_range(0, 9) < 2);
      s.ir    = ($urandom_range(0, 9) < 4);
      s.iresp = 1'($urandom_range(0, 1));
      s.dr    = ($urandom_range(0, 9) < 2);
      s.dw    = ($urandom_range(0, 9) < 1);
      s.dresp = 1'($urandom_range(0, 1));
      s.pclr  = ($urandom_range(0, 49) == 0);
      apply(s);
    end
    s = '0; apply(s);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drain", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
